// File: rtl/uno_hand.sv
// Player-hand manager for the UNO datapath: draws cards from the deck, keeps a scrollable hand,
// and returns a legally played card to the deck insert port.
module uno_hand #(
    parameter int MAX_CARDS = 32,
    parameter int IW        = $clog2(MAX_CARDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [2:0]    i_draw_req,
    input  logic          i_play,
    input  logic          i_sel_next,
    input  logic          i_sel_prev,
    input  logic [5:0]    i_top_card,
    input  logic          i_drawn,
    input  logic [5:0]    i_card,
    output logic [2:0]    o_draw,
    output logic          o_insert,
    output logic [5:0]    o_played_card,
    output logic [5:0]    o_sel_card,
    output logic [IW-1:0] o_sel_idx,
    output logic [IW:0]   o_count,
    output logic          o_legal,
    output logic          o_busy,
    output logic          o_illegal,
    output logic          o_overflow,
    output logic          o_uno
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PLAY} state_t;

    localparam logic [IW:0] CNT_ONE = (IW+1)'(1);
    localparam logic [IW:0] CNT_TWO = (IW+1)'(2);
    localparam logic [IW:0] CNT_MAX = (IW+1)'(MAX_CARDS);

    state_t        state;
    logic [5:0]    hand [MAX_CARDS];
    logic [IW:0]   count;
    logic [IW-1:0] sel;
    logic [2:0]    remaining;

    logic          draw_ok;
    logic [2:0]    draw_n;
    logic          play_ok;
    logic [IW:0]   count_m1;
    logic [IW:0]   count_m2;
    logic [IW-1:0] last_idx;
    logic [5:0]    hand_sel;

    // Wilds match anything; otherwise colour or value must match the discard top.
    function automatic logic is_playable(input logic [5:0] card, input logic [5:0] top);
        return (card[3:0] >= 4'd13) || (card[5:4] == top[5:4]) || (card[3:0] == top[3:0]);
    endfunction

    always_comb begin
        draw_ok = 1'b1;
        draw_n  = 3'd0;
        case (i_draw_req)
            3'b001:  draw_n = 3'd1;
            3'b010:  draw_n = 3'd2;
            3'b100:  draw_n = 3'd4;
            default: draw_ok = 1'b0;
        endcase
    end

    assign count_m1   = count - CNT_ONE;
    assign count_m2   = count - CNT_TWO;
    assign last_idx   = count_m1[IW-1:0];
    assign hand_sel   = hand[sel];

    assign o_sel_card = (count == '0) ? 6'd0 : hand_sel;
    assign o_sel_idx  = sel;
    assign o_count    = count;
    assign o_legal    = (count != '0) && is_playable(hand_sel, i_top_card);
    assign o_busy     = (state != S_IDLE);
    assign o_uno      = (count == CNT_ONE);
    assign play_ok    = i_play && o_legal;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            count         <= '0;
            sel           <= '0;
            remaining     <= 3'd0;
            o_draw        <= 3'd0;
            o_insert      <= 1'b0;
            o_played_card <= 6'd0;
            o_illegal     <= 1'b0;
            o_overflow    <= 1'b0;
            for (int i = 0; i < MAX_CARDS; i++) hand[i] <= 6'd0;
        end else begin
            o_insert   <= 1'b0;
            o_illegal  <= 1'b0;
            o_overflow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (draw_ok) begin
                        o_draw    <= i_draw_req;
                        remaining <= draw_n;
                        state     <= S_DRAW;
                    end else if (play_ok) begin
                        o_insert      <= 1'b1;
                        o_played_card <= hand_sel;
                        state         <= S_PLAY;
                    end else begin
                        if (i_play) o_illegal <= 1'b1;
                        if (count != '0 && (i_sel_next ^ i_sel_prev)) begin
                            if (i_sel_next) sel <= (sel == last_idx) ? '0 : sel + IW'(1);
                            else            sel <= (sel == '0) ? last_idx : sel - IW'(1);
                        end
                    end
                end
                S_DRAW: begin
                    if (i_drawn) begin
                        if (count < CNT_MAX) begin
                            hand[count[IW-1:0]] <= i_card;
                            count               <= count + CNT_ONE;
                        end else begin
                            o_overflow <= 1'b1;
                        end
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) begin
                            o_draw <= 3'd0;
                            state  <= S_IDLE;
                        end
                    end
                end
                S_PLAY: begin
                    // Swap-with-last removal keeps the occupied slots contiguous.
                    hand[sel]      <= hand[last_idx];
                    hand[last_idx] <= 6'd0;
                    count          <= count_m1;
                    if (sel == last_idx) sel <= (count > CNT_ONE) ? count_m2[IW-1:0] : '0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uno_hand.sv
// Directed self-checking bench for uno_hand: draw, play, cursor wrap, overflow, priority, reset abort.
module tb_uno_hand;

    localparam int MAX_CARDS = 32;
    localparam int IW = $clog2(MAX_CARDS);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [2:0]    i_draw_req = 3'd0;
    logic          i_play = 1'b0;
    logic          i_sel_next = 1'b0;
    logic          i_sel_prev = 1'b0;
    logic [5:0]    i_top_card = 6'd0;
    logic          i_drawn = 1'b0;
    logic [5:0]    i_card = 6'd0;
    logic [2:0]    o_draw;
    logic          o_insert;
    logic [5:0]    o_played_card;
    logic [5:0]    o_sel_card;
    logic [IW-1:0] o_sel_idx;
    logic [IW:0]   o_count;
    logic          o_legal;
    logic          o_busy;
    logic          o_illegal;
    logic          o_overflow;
    logic          o_uno;

    int tests = 0;
    int fails = 0;

    uno_hand #(.MAX_CARDS(MAX_CARDS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_draw_req(i_draw_req), .i_play(i_play),
        .i_sel_next(i_sel_next), .i_sel_prev(i_sel_prev), .i_top_card(i_top_card),
        .i_drawn(i_drawn), .i_card(i_card), .o_draw(o_draw), .o_insert(o_insert),
        .o_played_card(o_played_card), .o_sel_card(o_sel_card), .o_sel_idx(o_sel_idx),
        .o_count(o_count), .o_legal(o_legal), .o_busy(o_busy), .o_illegal(o_illegal),
        .o_overflow(o_overflow), .o_uno(o_uno)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step_cursor(input logic nxt, input logic prv);
        i_sel_next = nxt;
        i_sel_prev = prv;
        tick();
        i_sel_next = 1'b0;
        i_sel_prev = 1'b0;
    endtask

    // Issue a draw command and deliver n copies of card back to back.
    task automatic do_draw(input logic [2:0] req, input int n, input logic [5:0] card);
        i_draw_req = req;
        tick();
        i_draw_req = 3'd0;
        for (int k = 0; k < n; k++) begin
            i_drawn = 1'b1;
            i_card  = card;
            tick();
        end
        i_drawn = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        tests++; if (o_draw !== 3'd0) begin fails++; $display("FAIL reset_draw got %b exp 000", o_draw); end
        tests++; if (o_count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", o_count); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        tests++; if (o_sel_card !== 6'd0) begin fails++; $display("FAIL reset_sel_card got %h exp 00", o_sel_card); end
        tests++; if (o_legal !== 1'b0) begin fails++; $display("FAIL reset_legal got %b exp 0", o_legal); end
        tests++; if (o_uno !== 1'b0) begin fails++; $display("FAIL reset_uno got %b exp 0", o_uno); end
        tests++; if ({o_insert, o_illegal, o_overflow} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b exp 000", {o_insert, o_illegal, o_overflow}); end
    endtask

    task automatic test_draw_four();
        logic [5:0] cards [4];
        cards[0] = 6'h01; cards[1] = 6'h12; cards[2] = 6'h2D; cards[3] = 6'h3E;
        i_top_card = 6'h05;
        i_draw_req = 3'b100;
        tick();
        i_draw_req = 3'd0;
        tests++; if (o_draw !== 3'b100) begin fails++; $display("FAIL draw4_start got %b exp 100", o_draw); end
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL draw4_busy got %b exp 1", o_busy); end
        for (int k = 0; k < 4; k++) begin
            i_drawn = 1'b1;
            i_card  = cards[k];
            tick();
            i_drawn = 1'b0;
            tests++; if (o_count !== (IW+1)'(k + 1)) begin fails++; $display("FAIL draw4_count%0d got %0d exp %0d", k, o_count, k + 1); end
            tests++; if (o_draw !== ((k == 3) ? 3'b000 : 3'b100)) begin fails++; $display("FAIL draw4_odraw%0d got %b exp %b", k, o_draw, (k == 3) ? 3'b000 : 3'b100); end
            if (k != 3) begin
                tick();
                tests++; if (o_draw !== 3'b100) begin fails++; $display("FAIL draw4_gap%0d got %b exp 100", k, o_draw); end
            end
        end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL draw4_idle got %b exp 0", o_busy); end
        tests++; if (o_sel_card !== 6'h01 || o_legal !== 1'b1) begin fails++; $display("FAIL draw4_slot0 got %h/%b exp 01/1", o_sel_card, o_legal); end
        for (int k = 1; k < 4; k++) begin
            step_cursor(1'b1, 1'b0);
            tests++; if (o_sel_card !== cards[k]) begin fails++; $display("FAIL draw4_slot%0d got %h exp %h", k, o_sel_card, cards[k]); end
        end
        step_cursor(1'b1, 1'b0);
        tests++; if (o_sel_idx !== '0) begin fails++; $display("FAIL draw4_wrap got %0d exp 0", o_sel_idx); end
    endtask

    task automatic test_play();
        step_cursor(1'b1, 1'b0);
        tests++; if (o_sel_card !== 6'h12 || o_legal !== 1'b0) begin fails++; $display("FAIL play_sel12 got %h/%b exp 12/0", o_sel_card, o_legal); end
        i_play = 1'b1;
        tick();
        i_play = 1'b0;
        tests++; if (o_illegal !== 1'b1 || o_insert !== 1'b0) begin fails++; $display("FAIL play_illegal got %b/%b exp 1/0", o_illegal, o_insert); end
        tests++; if (o_count !== (IW+1)'(4) || o_busy !== 1'b0) begin fails++; $display("FAIL play_illegal_state got %0d/%b exp 4/0", o_count, o_busy); end
        tick();
        tests++; if (o_illegal !== 1'b0) begin fails++; $display("FAIL play_illegal_pulse got %b exp 0", o_illegal); end
        step_cursor(1'b1, 1'b0);
        tests++; if (o_sel_card !== 6'h2D || o_legal !== 1'b1) begin fails++; $display("FAIL play_sel2d got %h/%b exp 2d/1", o_sel_card, o_legal); end
        i_play = 1'b1;
        tick();
        i_play = 1'b0;
        tests++; if (o_insert !== 1'b1 || o_played_card !== 6'h2D) begin fails++; $display("FAIL play_insert got %b/%h exp 1/2d", o_insert, o_played_card); end
        tests++; if (o_busy !== 1'b1 || o_count !== (IW+1)'(4)) begin fails++; $display("FAIL play_busy got %b/%0d exp 1/4", o_busy, o_count); end
        tick();
        tests++; if (o_insert !== 1'b0 || o_count !== (IW+1)'(3)) begin fails++; $display("FAIL play_done got %b/%0d exp 0/3", o_insert, o_count); end
        tests++; if (o_sel_idx !== IW'(2) || o_sel_card !== 6'h3E) begin fails++; $display("FAIL play_swap got %0d/%h exp 2/3e", o_sel_idx, o_sel_card); end
    endtask

    task automatic test_cursor_wrap();
        step_cursor(1'b1, 1'b0);
        tests++; if (o_sel_idx !== IW'(0) || o_sel_card !== 6'h01) begin fails++; $display("FAIL cur_next_wrap got %0d/%h exp 0/01", o_sel_idx, o_sel_card); end
        step_cursor(1'b0, 1'b1);
        tests++; if (o_sel_idx !== IW'(2)) begin fails++; $display("FAIL cur_prev_wrap got %0d exp 2", o_sel_idx); end
        step_cursor(1'b1, 1'b1);
        tests++; if (o_sel_idx !== IW'(2)) begin fails++; $display("FAIL cur_both got %0d exp 2", o_sel_idx); end
        step_cursor(1'b0, 1'b1);
        tests++; if (o_sel_idx !== IW'(1) || o_sel_card !== 6'h12) begin fails++; $display("FAIL cur_prev got %0d/%h exp 1/12", o_sel_idx, o_sel_card); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 7; k++) do_draw(3'b100, 4, 6'h07);
        do_draw(3'b001, 1, 6'h07);
        tests++; if (o_count !== (IW+1)'(MAX_CARDS)) begin fails++; $display("FAIL ovf_full got %0d exp %0d", o_count, MAX_CARDS); end
        i_draw_req = 3'b010;
        tick();
        i_draw_req = 3'd0;
        tests++; if (o_draw !== 3'b010) begin fails++; $display("FAIL ovf_odraw got %b exp 010", o_draw); end
        i_drawn = 1'b1;
        i_card  = 6'h33;
        tick();
        tests++; if (o_overflow !== 1'b1 || o_count !== (IW+1)'(MAX_CARDS)) begin fails++; $display("FAIL ovf_first got %b/%0d exp 1/%0d", o_overflow, o_count, MAX_CARDS); end
        tick();
        i_drawn = 1'b0;
        tests++; if (o_overflow !== 1'b1 || o_busy !== 1'b0 || o_draw !== 3'b000) begin fails++; $display("FAIL ovf_second got %b/%b/%b exp 1/0/000", o_overflow, o_busy, o_draw); end
        tick();
        tests++; if (o_overflow !== 1'b0 || o_count !== (IW+1)'(MAX_CARDS)) begin fails++; $display("FAIL ovf_end got %b/%0d exp 0/%0d", o_overflow, o_count, MAX_CARDS); end
    endtask

    task automatic test_priority();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        do_draw(3'b001, 1, 6'h0D);
        tests++; if (o_uno !== 1'b1 || o_legal !== 1'b1) begin fails++; $display("FAIL prio_uno got %b/%b exp 1/1", o_uno, o_legal); end
        i_draw_req = 3'b001;
        i_play     = 1'b1;
        tick();
        i_draw_req = 3'd0;
        i_play     = 1'b0;
        tests++; if (o_draw !== 3'b001 || o_busy !== 1'b1 || o_insert !== 1'b0 || o_illegal !== 1'b0) begin fails++; $display("FAIL prio_draw got %b/%b/%b/%b exp 001/1/0/0", o_draw, o_busy, o_insert, o_illegal); end
        i_drawn = 1'b1;
        i_card  = 6'h11;
        tick();
        i_drawn = 1'b0;
        tests++; if (o_count !== (IW+1)'(2) || o_insert !== 1'b0 || o_uno !== 1'b0) begin fails++; $display("FAIL prio_count got %0d/%b/%b exp 2/0/0", o_count, o_insert, o_uno); end
        i_draw_req = 3'b011;
        tick();
        i_draw_req = 3'd0;
        tests++; if (o_busy !== 1'b0 || o_draw !== 3'b000) begin fails++; $display("FAIL prio_nonhot got %b/%b exp 0/000", o_busy, o_draw); end
    endtask

    task automatic test_reset_mid_draw();
        i_draw_req = 3'b010;
        tick();
        i_draw_req = 3'd0;
        i_drawn = 1'b1;
        i_card  = 6'h24;
        tick();
        i_drawn = 1'b0;
        tests++; if (o_count !== (IW+1)'(3) || o_draw !== 3'b010) begin fails++; $display("FAIL rstmid_pre got %0d/%b exp 3/010", o_count, o_draw); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tests++; if (o_draw !== 3'b000 || o_count !== '0 || o_busy !== 1'b0) begin fails++; $display("FAIL rstmid_abort got %b/%0d/%b exp 000/0/0", o_draw, o_count, o_busy); end
        i_drawn = 1'b1;
        i_card  = 6'h25;
        tick();
        i_drawn = 1'b0;
        tests++; if (o_count !== '0 || o_sel_card !== 6'd0) begin fails++; $display("FAIL rstmid_ignore got %0d/%h exp 0/00", o_count, o_sel_card); end
    endtask

    initial begin
        test_reset();
        test_draw_four();
        test_play();
        test_cursor_wrap();
        test_overflow();
        test_priority();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
